s38584_chain776_seq: RTL and testbench

Sequential register stage directly downstream of the g776 next-state cone in the s38584 partial-output set. It owns the g739…g781 stage chain, consumes the gating conditions that cone evaluates, and registers the g776/g781 pair every enabled cycle. It adds a small sequencing FSM and a pass counter, and feeds its registered bits back to the cone logic as that logic's state inputs.

---
 rtl/s38584_chain776_seq_if.sv | 59 +++++
 rtl/s38584_chain776_seq.sv | 129 ++++++++++++
 tb/tb_s38584_chain776_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/s38584_chain776_seq_if.sv
// Handshake/bus bundle for the g776 stage:
// gating inputs, chain head and registered outputs.
interface s38584_chain776_seq_if;
    logic       g35;
    logic       g802;
    logic       g736;
    logic       g799;
    logic       g655;
    logic       g753;
    logic       g718;
    logic       g807;
    logic       g554;
    logic       g370;
    logic       g358;
    logic       g376;
    logic       g385;
    logic       g482;
    logic       g490;
    logic       g528;
    logic       g499;
    logic       g518;
    logic       chain_in;
    logic       g739;
    logic       g744;
    logic       g749;
    logic       g758;
    logic       g763;
    logic       g767;
    logic       g772;
    logic       g776;
    logic       g781;
    logic [1:0] fsm_state;
    logic [3:0] pass_cnt;
    logic       wrap;

    modport master (
        output g35, g802, g736, g799,
        output g655, g753, g718, g807, g554,
        output g370, g358, g376, g385,
        output g482, g490, g528, g499, g518,
        output chain_in,
        input  g739, g744, g749, g758,
        input  g763, g767, g772,
        input  g776, g781,
        input  fsm_state, pass_cnt, wrap
    );

    modport slave (
        input  g35, g802, g736, g799,
        input  g655, g753, g718, g807, g554,
        input  g370, g358, g376, g385,
        input  g482, g490, g528, g499, g518,
        input  chain_in,
        output g739, g744, g749, g758,
        output g763, g767, g772,
        output g776, g781,
        output fsm_state, pass_cnt, wrap
    );
endinterface

// File: rtl/s38584_chain776_seq.sv
// g739..g781 stage chain with g776/g781 tail pair,
// sequencing FSM and g776 rising-edge pass counter.
module s38584_chain776_seq (
    input  logic                  CK,
    input  logic                  RN,
    s38584_chain776_seq_if.slave  io_bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    logic [6:0] r_chain;
    logic       r_g776;
    logic       r_g781;
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_wrap;

    logic       w_byp;
    logic       w_vote_ok;
    logic       w_stat_ok;
    logic       w_act_ok;
    logic       w_gate_ok;
    logic       w_all_ok;
    logic       w_g776_nxt;
    logic [6:0] w_chain_nxt;
    logic       w_next_empty;
    logic       w_rise;
    logic [1:0] w_state_nxt;

    assign w_byp = io_bus.g802 & ~io_bus.g736;

    assign w_vote_ok =
        (io_bus.g655 | io_bus.g753 | io_bus.g718) &
        ~(io_bus.g655 & io_bus.g753 & io_bus.g718 &
          ~(io_bus.g554 & io_bus.g807));

    assign w_stat_ok = ~io_bus.g370 & io_bus.g358 &
                       io_bus.g376 & io_bus.g385;

    assign w_act_ok = io_bus.g482 | io_bus.g490 |
                      io_bus.g528 | io_bus.g499 |
                      io_bus.g518;

    assign w_gate_ok = (io_bus.g802 | ~io_bus.g799) &
                       w_vote_ok & w_stat_ok & w_act_ok;

    // every chain bit must be set unless bypassed
    assign w_all_ok = w_gate_ok & (&(r_chain | {7{w_byp}}));

    assign w_g776_nxt = w_all_ok ? ~r_g781
                                 : (r_g781 & ~w_byp);

    assign w_chain_nxt  = {r_chain[5:0], io_bus.chain_in};
    assign w_next_empty = ~|w_chain_nxt;
    assign w_rise       = ~r_g776 & w_g776_nxt;

    // sequencing FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.chain_in)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_next_empty)
                    w_state_nxt = ST_IDLE;
                else if (w_all_ok)
                    w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_next_empty)
                    w_state_nxt = ST_IDLE;
                else if (!w_all_ok)
                    w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // chain shift and tail pair
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_chain <= '0;
            r_g776  <= 1'b0;
            r_g781  <= 1'b0;
        end else if (io_bus.g35) begin
            r_chain <= w_chain_nxt;
            r_g776  <= w_g776_nxt;
            r_g781  <= r_g776;
        end
    end

    // FSM state register
    always_ff @(posedge CK or negedge RN) begin
        if (!RN)
            r_state <= ST_IDLE;
        else if (io_bus.g35)
            r_state <= w_state_nxt;
    end

    // pass counter; wrap is a one-cycle pulse, cleared on hold
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (io_bus.g35) begin
            if (w_rise)
                r_cnt <= r_cnt + 4'd1;
            r_wrap <= w_rise & (r_cnt == 4'd15);
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign io_bus.g739     = r_chain[0];
    assign io_bus.g744     = r_chain[1];
    assign io_bus.g749     = r_chain[2];
    assign io_bus.g758     = r_chain[3];
    assign io_bus.g763     = r_chain[4];
    assign io_bus.g767     = r_chain[5];
    assign io_bus.g772     = r_chain[6];
    assign io_bus.g776     = r_g776;
    assign io_bus.g781     = r_g781;
    assign io_bus.fsm_state = r_state;
    assign io_bus.pass_cnt = r_cnt;
    assign io_bus.wrap     = r_wrap;
endmodule

// File: tb/tb_s38584_chain776_seq.sv
// Self-checking bench for s38584_chain776_seq: vector table,
// directed corner sequences and random run against a model.
module tb_s38584_chain776_seq;
    logic CK = 1'b0;
    logic RN = 1'b0;

    s38584_chain776_seq_if bus();

    s38584_chain776_seq dut (
        .CK     (CK),
        .RN     (RN),
        .io_bus (bus)
    );

    always #5 CK = ~CK;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural reference state
    bit m_ch [7];
    bit m_776;
    bit m_781;
    int m_fsm;
    int m_cnt;
    bit m_wrap;

    typedef struct {
        bit         en;
        bit         cin;
        logic [6:0] ch;
        bit         e776;
        bit         e781;
        logic [1:0] fsm;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(string name, logic [15:0] act,
                       logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    function automatic logic [15:0] dut_word();
        return {bus.g772, bus.g767, bus.g763, bus.g758,
                bus.g749, bus.g744, bus.g739,
                bus.g776, bus.g781, bus.fsm_state,
                bus.pass_cnt, bus.wrap};
    endfunction

    function automatic logic [15:0] model_word();
        logic [6:0] c;
        for (int i = 0; i < 7; i++) c[i] = m_ch[i];
        return {c, m_776, m_781, 2'(m_fsm),
                4'(m_cnt), m_wrap};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) m_ch[i] = 0;
        m_776 = 0; m_781 = 0; m_fsm = 0;
        m_cnt = 0; m_wrap = 0;
    endtask

    // one enabled/held clock of the specified behaviour
    task automatic model_step();
        bit byp, vote, stat, act, allok, n776, empty;
        byp  = bus.g802 && !bus.g736;
        vote = (bus.g655 || bus.g753 || bus.g718) &&
               !(bus.g655 && bus.g753 && bus.g718 &&
                 !(bus.g554 && bus.g807));
        stat = !bus.g370 && bus.g358 && bus.g376 && bus.g385;
        act  = bus.g482 || bus.g490 || bus.g528 ||
               bus.g499 || bus.g518;
        if (!bus.g35) begin
            m_wrap = 0;
            return;
        end
        allok = (bus.g802 || !bus.g799) && vote && stat && act;
        for (int i = 0; i < 7; i++)
            allok = allok && (byp || m_ch[i]);
        n776 = allok ? !m_781 : (m_781 && !byp);
        m_wrap = 0;
        if (!m_776 && n776) begin
            m_cnt = (m_cnt + 1) % 16;
            m_wrap = (m_cnt == 0);
        end
        m_781 = m_776;
        m_776 = n776;
        for (int i = 6; i > 0; i--) m_ch[i] = m_ch[i-1];
        m_ch[0] = bus.chain_in;
        empty = 1;
        for (int i = 0; i < 7; i++)
            if (m_ch[i]) empty = 0;
        case (m_fsm)
            0: if (bus.chain_in) m_fsm = 1;
            1: if (empty) m_fsm = 0;
               else if (allok) m_fsm = 2;
            default: if (empty) m_fsm = 0;
                     else if (!allok) m_fsm = 1;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge CK);
        #1;
        chk("model", dut_word(), model_word());
    endtask

    task automatic rst_pulse();
        RN = 1'b0;
        #1;
        model_reset();
        chk("async_rst", dut_word(), 16'h0000);
        #1;
        RN = 1'b1;
    endtask

    task automatic cfg_zero();
        bus.g35 = 1; bus.g802 = 0; bus.g736 = 0; bus.g799 = 0;
        bus.g655 = 0; bus.g753 = 0; bus.g718 = 0;
        bus.g807 = 0; bus.g554 = 0;
        bus.g370 = 0; bus.g358 = 0; bus.g376 = 0; bus.g385 = 0;
        bus.g482 = 0; bus.g490 = 0; bus.g528 = 0;
        bus.g499 = 0; bus.g518 = 0; bus.chain_in = 0;
    endtask

    task automatic cfg_bypass();
        cfg_zero();
        bus.g802 = 1; bus.g799 = 1; bus.g655 = 1;
        bus.g358 = 1; bus.g376 = 1; bus.g385 = 1;
        bus.g482 = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps;

        tbl[0]  = '{1, 1, 7'b0000001, 1, 0, 2'd1, 4'd1};
        tbl[1]  = '{1, 1, 7'b0000011, 1, 1, 2'd2, 4'd1};
        tbl[2]  = '{1, 0, 7'b0000110, 0, 1, 2'd2, 4'd1};
        tbl[3]  = '{0, 1, 7'b0000110, 0, 1, 2'd2, 4'd1};
        tbl[4]  = '{0, 1, 7'b0000110, 0, 1, 2'd2, 4'd1};
        tbl[5]  = '{0, 1, 7'b0000110, 0, 1, 2'd2, 4'd1};
        tbl[6]  = '{1, 0, 7'b0001100, 0, 0, 2'd2, 4'd1};
        tbl[7]  = '{1, 0, 7'b0011000, 1, 0, 2'd2, 4'd2};
        tbl[8]  = '{1, 0, 7'b0110000, 1, 1, 2'd2, 4'd2};
        tbl[9]  = '{1, 0, 7'b1100000, 0, 1, 2'd2, 4'd2};
        tbl[10] = '{1, 0, 7'b1000000, 0, 0, 2'd2, 4'd2};
        tbl[11] = '{1, 0, 7'b0000000, 1, 0, 2'd0, 4'd3};

        cfg_zero();
        model_reset();
        #12;
        chk("reset_state", dut_word(), 16'h0000);
        #1;
        RN = 1'b1;
        @(posedge CK);
        #1;

        // bypass arm and hold, table driven
        cfg_bypass();
        for (int i = 0; i < 12; i++) begin
            bus.g35 = tbl[i].en;
            bus.chain_in = tbl[i].cin;
            tick();
            chk($sformatf("vec%0d", i), dut_word(),
                {tbl[i].ch, tbl[i].e776, tbl[i].e781,
                 tbl[i].fsm, tbl[i].cnt, 1'b0});
        end

        // reset mid-run
        rst_pulse();
        cfg_zero();
        bus.chain_in = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("chain_loaded", 16'(bus.g749), 16'd1);
        rst_pulse();
        bus.chain_in = 0;
        tick();
        chk("post_rst_edge", dut_word(), 16'h0000);

        // token walk, all_ok false
        cfg_zero();
        bus.g370 = 1;
        bus.chain_in = 1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            bus.chain_in = 0;
            chk($sformatf("walk776_%0d", e), 16'(bus.g776), 16'd0);
            if (e == 1)
                chk("walk_g739", 16'(bus.g739), 16'd1);
            if (e == 7)
                chk("walk_g772", 16'(bus.g772), 16'd1);
            if (e == 8)
                chk("walk_idle", 16'(bus.fsm_state), 16'd0);
        end

        // counter wrap over 64 enabled edges
        rst_pulse();
        cfg_bypass();
        wraps = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (bus.wrap) wraps++;
            chk($sformatf("cnt_%0d", k), 16'(bus.pass_cnt),
                16'(((k + 3) / 4) % 16));
            if (k == 61)
                chk("wrap_edge", 16'(bus.wrap), 16'd1);
        end
        chk("wrap_once", 16'(wraps), 16'd1);
        chk("cnt_end", 16'(bus.pass_cnt), 16'd0);

        // triple-vote override
        rst_pulse();
        cfg_bypass();
        bus.chain_in = 1;
        tick();
        tick();
        chk("vote_armed", 16'(bus.fsm_state), 16'd2);
        bus.g655 = 1; bus.g753 = 1; bus.g718 = 1;
        tick();
        chk("vote_run", 16'(bus.fsm_state), 16'd1);
        bus.g554 = 1; bus.g807 = 1;
        tick();
        chk("vote_rearm", 16'(bus.fsm_state), 16'd2);

        // randomized run against the model
        for (int n = 0; n < 400; n++) begin
            bus.g35  = ($urandom_range(0, 9) != 0);
            bus.g802 = 1'($urandom);
            bus.g736 = ($urandom_range(0, 3) == 0);
            bus.g799 = 1'($urandom);
            bus.g655 = 1'($urandom);
            bus.g753 = 1'($urandom);
            bus.g718 = 1'($urandom);
            bus.g807 = 1'($urandom);
            bus.g554 = 1'($urandom);
            bus.g370 = ($urandom_range(0, 7) == 0);
            bus.g358 = ($urandom_range(0, 7) != 0);
            bus.g376 = ($urandom_range(0, 7) != 0);
            bus.g385 = ($urandom_range(0, 7) != 0);
            bus.g482 = 1'($urandom);
            bus.g490 = 1'($urandom);
            bus.g528 = 1'($urandom);
            bus.g499 = 1'($urandom);
            bus.g518 = 1'($urandom);
            bus.chain_in = ($urandom_range(0, 2) != 0);
            tick();
            if ($urandom_range(0, 49) == 0)
                rst_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
